// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers, the switch allocator and the crossbar selects.
// master = input-buffer/crossbar side, slave = allocator side.
interface switch_allocator_if;
  logic [4:0] valid;
  logic [4:0] req0, req1, req2, req3, req4;
  logic [4:0] tail;
  logic [4:0] out_rdy;
  logic [4:0] sel0, sel1, sel2, sel3, sel4;
  logic [4:0] gnt;
  logic [4:0] req_err;

  modport master (
    output valid, req0, req1, req2, req3, req4, tail, out_rdy,
    input  sel0, sel1, sel2, sel3, sel4, gnt, req_err
  );

  modport slave (
    input  valid, req0, req1, req2, req3, req4, tail, out_rdy,
    output sel0, sel1, sel2, sel3, sel4, gnt, req_err
  );
endinterface

// File: rtl/switch_allocator.sv
// Five-port wormhole switch allocator: per-output round-robin arbitration with lock until tail,
// optional lock timeout, registered one-hot crossbar selects and per-input grants.
module switch_allocator #(
  parameter int NPORT   = 5,
  parameter int TIMEOUT = 0
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);
  localparam int W = NPORT;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e       state_q [W];
  state_e       state_d [W];
  logic [2:0]   ptr_q   [W];
  logic [2:0]   ptr_d   [W];
  logic [2:0]   owner_q [W];
  logic [2:0]   owner_d [W];
  logic [7:0]   cnt_q   [W];
  logic [7:0]   cnt_d   [W];
  logic [W-1:0] sel_q   [W];
  logic [W-1:0] sel_d   [W];
  logic [W-1:0] req_a   [W];
  logic [W-1:0] cand    [W];
  logic [W-1:0] onehot;
  logic [W-1:0] busy;
  logic [W-1:0] gnt_q, gnt_d;
  logic [W-1:0] err_q, err_d;

  assign req_a[0] = bus.req0;
  assign req_a[1] = bus.req1;
  assign req_a[2] = bus.req2;
  assign req_a[3] = bus.req3;
  assign req_a[4] = bus.req4;

  function automatic logic is_onehot(input logic [W-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'(W - 1)) ? 3'd0 : v + 3'd1;
  endfunction

  // An input that still owns any output (including one releasing this edge) is not a candidate.
  always_comb begin
    for (int j = 0; j < W; j++) begin
      onehot[j] = is_onehot(req_a[j]);
      err_d[j]  = bus.valid[j] & ~onehot[j];
      busy[j]   = 1'b0;
      for (int k = 0; k < W; k++) begin
        if (state_q[k] == LOCKED && owner_q[k] == 3'(j)) busy[j] = 1'b1;
      end
    end
    for (int k = 0; k < W; k++) begin
      for (int j = 0; j < W; j++) begin
        cand[k][j] = bus.valid[j] & onehot[j] & req_a[j][k] & ~busy[j];
      end
    end
  end

  always_comb begin : next_state
    logic       found;
    logic [2:0] win;
    logic [2:0] w;
    logic [2:0] idx;
    logic [3:0] pos;
    logic [7:0] cnt_inc;
    logic       rel;
    gnt_d = '0;
    for (int k = 0; k < W; k++) begin
      state_d[k] = state_q[k];
      ptr_d[k]   = ptr_q[k];
      owner_d[k] = owner_q[k];
      cnt_d[k]   = cnt_q[k];
      sel_d[k]   = sel_q[k];
      found      = 1'b0;
      win        = 3'd0;
      idx        = 3'd0;
      pos        = 4'd0;
      w          = owner_q[k];
      cnt_inc    = cnt_q[k] + 8'd1;
      rel        = (gnt_q[w] & bus.valid[w] & bus.tail[w]) ||
                   ((TIMEOUT != 0) && (cnt_inc == 8'(TIMEOUT)));
      if (state_q[k] == IDLE) begin
        for (int i = 0; i < W; i++) begin
          pos = {1'b0, ptr_q[k]} + 4'(i);
          if (pos >= 4'(W)) pos = pos - 4'(W);
          idx = pos[2:0];
          if (!found && cand[k][idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          state_d[k] = LOCKED;
          owner_d[k] = win;
          sel_d[k]   = ONE << win;
          cnt_d[k]   = 8'd0;
        end
      end else if (rel) begin
        // Released output sits IDLE for a cycle before it can arbitrate again.
        state_d[k] = IDLE;
        sel_d[k]   = '0;
        ptr_d[k]   = wrap_inc(w);
        cnt_d[k]   = 8'd0;
      end else begin
        cnt_d[k] = cnt_inc;
      end
    end
    for (int j = 0; j < W; j++) begin
      for (int k = 0; k < W; k++) begin
        if (state_d[k] == LOCKED && owner_d[k] == 3'(j) && bus.out_rdy[k]) gnt_d[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < W; k++) begin
        state_q[k] <= IDLE;
        ptr_q[k]   <= '0;
        owner_q[k] <= '0;
        cnt_q[k]   <= '0;
        sel_q[k]   <= '0;
      end
      gnt_q <= '0;
      err_q <= '0;
    end else begin
      for (int k = 0; k < W; k++) begin
        state_q[k] <= state_d[k];
        ptr_q[k]   <= ptr_d[k];
        owner_q[k] <= owner_d[k];
        cnt_q[k]   <= cnt_d[k];
        sel_q[k]   <= sel_d[k];
      end
      gnt_q <= gnt_d;
      err_q <= err_d;
    end
  end

  assign bus.sel0    = sel_q[0];
  assign bus.sel1    = sel_q[1];
  assign bus.sel2    = sel_q[2];
  assign bus.sel3    = sel_q[3];
  assign bus.sel4    = sel_q[4];
  assign bus.gnt     = gnt_q;
  assign bus.req_err = err_q;
endmodule

// File: tb/tb_switch_allocator.sv
// Directed scoreboard bench for switch_allocator: stimulus pushes expected post-edge outputs,
// a monitor pops and compares them one cycle later.
module tb_switch_allocator;
  logic clk = 1'b0;
  logic rst = 1'b0;

  switch_allocator_if bus ();

  switch_allocator #(.NPORT(5), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [24:0] sel;
    logic [4:0]  gnt;
    logic [4:0]  err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [24:0] sl(int k, int j);
    logic [24:0] v;
    v = 25'd1 << (5 * k + j);
    return v;
  endfunction

  task automatic chk(string name, logic [24:0] es, logic [4:0] eg, logic [4:0] ee);
    logic [24:0] as;
    as = {bus.sel4, bus.sel3, bus.sel2, bus.sel1, bus.sel0};
    checks++;
    if (as !== es || bus.gnt !== eg || bus.req_err !== ee) begin
      errors++;
      $display("FAIL %s: got sel=%h gnt=%b req_err=%b, want sel=%h gnt=%b req_err=%b",
               name, as, bus.gnt, bus.req_err, es, eg, ee);
    end
  endtask

  task automatic drive(logic [4:0] v, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                       logic [4:0] r3, logic [4:0] r4, logic [4:0] t, logic [4:0] rdy);
    bus.valid   = v;
    bus.req0    = r0;
    bus.req1    = r1;
    bus.req2    = r2;
    bus.req3    = r3;
    bus.req4    = r4;
    bus.tail    = t;
    bus.out_rdy = rdy;
  endtask

  task automatic step(string name, logic [24:0] es, logic [4:0] eg, logic [4:0] ee);
    exp_t e;
    e.cyc  = cycle + 1;
    e.sel  = es;
    e.gnt  = eg;
    e.err  = ee;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(string name);
    drive('0, '0, '0, '0, '0, '0, '0, 5'b11111);
    step(name, '0, '0, '0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cycle++;
      #2;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cycle) begin
        e = exp_q.pop_front();
        chk(e.name, e.sel, e.gnt, e.err);
      end
    end
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    drive('0, '0, '0, '0, '0, '0, '0, 5'b11111);
    #1 rst = 1'b1;
    #1 chk("reset_state", '0, '0, '0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single requester on output 2, tail on third granted cycle
    drive(5'b00001, 5'b00100, '0, '0, '0, '0, '0, 5'b11111);
    step("single_lock", sl(2, 0), 5'b00001, '0);
    step("single_hold1", sl(2, 0), 5'b00001, '0);
    step("single_hold2", sl(2, 0), 5'b00001, '0);
    drive(5'b00001, 5'b00100, '0, '0, '0, '0, 5'b00001, 5'b11111);
    step("single_release", '0, '0, '0);
    idle("single_idle");

    // ptr_2 is now 1: input 2 beats input 0, then pointer wraps back to 0
    drive(5'b00101, 5'b00100, '0, 5'b00100, '0, '0, 5'b00101, 5'b11111);
    step("ptr2_picks_in2", sl(2, 2), 5'b00100, '0);
    step("release_in2", '0, '0, '0);
    drive(5'b00001, 5'b00100, '0, '0, '0, '0, 5'b00001, 5'b11111);
    step("rr_wrap_in0", sl(2, 0), 5'b00001, '0);
    step("release_in0", '0, '0, '0);
    idle("idle_after_wrap");

    // Async reset with output 2 locked by input 4 (ptr_2 = 1 beforehand)
    drive(5'b10000, '0, '0, '0, '0, 5'b00100, '0, 5'b11111);
    step("lock_in4", sl(2, 4), 5'b10000, '0);
    step("hold_in4", sl(2, 4), 5'b10000, '0);
    #3 rst = 1'b1;
    #1 chk("async_reset_mid_cycle", '0, '0, '0);
    drive('0, '0, '0, '0, '0, '0, '0, 5'b11111);
    #2 rst = 1'b0;
    drive(5'b10001, 5'b00100, '0, '0, '0, 5'b00100, 5'b10001, 5'b11111);
    step("ptr_reset_in0_wins", sl(2, 0), 5'b00001, '0);
    step("release_in0_post_rst", '0, '0, '0);
    drive(5'b10000, '0, '0, '0, '0, 5'b00100, 5'b10000, 5'b11111);
    step("in4_post_rst", sl(2, 4), 5'b10000, '0);
    step("release_in4", '0, '0, '0);
    idle("idle_after_reset");

    // Contention on output 0: inputs 1,3,4 single-flit packets
    drive(5'b11010, '0, 5'b00001, '0, 5'b00001, 5'b00001, 5'b11010, 5'b11111);
    step("rr_win_in1", sl(0, 1), 5'b00010, '0);
    step("rr_bubble1", '0, '0, '0);
    step("rr_win_in3", sl(0, 3), 5'b01000, '0);
    step("rr_bubble2", '0, '0, '0);
    step("rr_win_in4", sl(0, 4), 5'b10000, '0);
    step("rr_bubble3", '0, '0, '0);
    step("rr_win_in1_again", sl(0, 1), 5'b00010, '0);
    step("rr_bubble4", '0, '0, '0);
    idle("idle_after_rr");

    // Backpressure on output 3
    drive(5'b00001, 5'b01000, '0, '0, '0, '0, '0, 5'b10111);
    step("bp_lock_no_gnt", sl(3, 0), '0, '0);
    step("bp_hold1", sl(3, 0), '0, '0);
    drive(5'b00001, 5'b01000, '0, '0, '0, '0, 5'b00001, 5'b10111);
    step("bp_tail_no_gnt", sl(3, 0), '0, '0);
    step("bp_hold3", sl(3, 0), '0, '0);
    drive(5'b00001, 5'b01000, '0, '0, '0, '0, 5'b00001, 5'b11111);
    step("bp_gnt_resume", sl(3, 0), 5'b00001, '0);
    step("bp_release", '0, '0, '0);
    idle("idle_after_bp");

    // Timeout of 8 locked cycles on output 1, input 3 waiting
    drive(5'b01100, '0, '0, 5'b00010, 5'b00010, '0, '0, 5'b11111);
    step("to_lock_in2", sl(1, 2), 5'b00100, '0);
    for (int i = 0; i < 7; i++) step("to_hold", sl(1, 2), 5'b00100, '0);
    step("to_forced_release", '0, '0, '0);
    step("to_next_in3", sl(1, 3), 5'b01000, '0);
    drive('0, '0, '0, '0, 5'b00010, '0, '0, 5'b11111);
    step("to_valid_low_holds", sl(1, 3), 5'b01000, '0);
    drive(5'b01000, '0, '0, '0, 5'b00010, '0, 5'b01000, 5'b11111);
    step("to_release_in3", '0, '0, '0);
    idle("idle_after_to");

    // Bad requests; output 4 arbitrates normally alongside
    drive(5'b00101, 5'b10000, '0, 5'b00110, '0, '0, 5'b00001, 5'b11111);
    step("bad_req_err", sl(4, 0), 5'b00001, 5'b00100);
    drive(5'b00001, 5'b10000, '0, 5'b00110, '0, '0, 5'b00001, 5'b11111);
    step("bad_req_pulse_end", '0, '0, '0);
    drive(5'b00100, '0, '0, '0, '0, '0, '0, 5'b11111);
    step("zero_req_err", '0, '0, 5'b00100);
    drive('0, '0, '0, 5'b00110, '0, '0, '0, 5'b11111);
    step("invalid_bad_req_quiet", '0, '0, '0);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Five-port round-robin switch allocator for the mesh router. It sits directly upstream of the 5x5 crossbar and drives the crossbar's one-hot select buses sel0..sel4.
- Per output port it arbitrates among input ports requesting that output and locks the winner until the winner's tail flit passes (wormhole).
- It returns a per-input grant so the input buffers know when to launch flits.

Parameters:
- NPORT, 5, number of ports; only 5 is supported (sel widths are fixed at 5).
- TIMEOUT, 0, max consecutive locked cycles per output before forced release; 0 disables the timeout. Range 0..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid  in  5  bit j: input j holds a flit.
- req0..req4  in  5 each  one-hot requested output for input j; bit k = output k.
- tail  in  5  bit j: input j's current flit is a tail flit.
- out_rdy  in  5  bit k: downstream of output k can accept a flit.
- sel0..sel4  out  5 each  one-hot input select for output k; bit j = input j. Encoding matches the crossbar's select inputs; all-zero means the output is unused.
- gnt  out  5  bit j: input j may send its flit this cycle.
- req_err  out  5  bit j: one-cycle pulse when input j is valid but reqj is not one-hot.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on rst; it clears all state immediately, independent of clk.
- Reset values: sel0..sel4=0, gnt=0, req_err=0, all round-robin pointers ptr_k=0, all outputs IDLE, timeout counters=0.
- Per-output state machine k has two states, IDLE and LOCKED.
- Candidates in IDLE: input j with valid[j]=1, reqj one-hot with reqj[k]=1, and j not currently owner of any output.
- IDLE -> LOCKED: the winner is the first candidate found searching j=ptr_k, ptr_k+1, ... mod 5. At the edge, sel_k <= onehot(winner) and owner_k <= winner. Latency: request at cycle t, sel_k visible at t+1.
- IDLE with no candidate: stay IDLE, sel_k=0.
- LOCKED: sel_k holds and reqj changes are ignored. gnt[owner] is registered: gnt[owner] <= out_rdy[k] each cycle, so sel and gnt are aligned for the crossbar's registered output stage.
- Release: at an edge where gnt[w]=1, valid[w]=1 and tail[w]=1, the output goes to IDLE and ptr_k <= (w+1) mod 5. sel_k and gnt[w] are 0 from the next cycle. The output stays IDLE for at least one cycle (one-cycle bubble) before re-arbitration.
- Single-flit packet (head=tail): lock, one grant cycle, release.
- Timeout (TIMEOUT>0): an 8-bit counter per locked output increments each locked cycle and clears on lock. When it reaches TIMEOUT, force release and advance ptr_k the same way as a normal release.
- One input owns at most one output. Different outputs arbitrate independently in the same cycle.
- Simultaneous events:
  - Two outputs releasing and re-locking are independent.
  - An input released from output k is excluded from candidates on its release edge and eligible from the next cycle.
- Non-one-hot req with valid=1: input is ignored for arbitration and req_err[j] pulses for one cycle per offending cycle. A zero req with valid=1 also counts as an error.
- valid[w]=0 while LOCKED: the lock holds; gnt still follows out_rdy; no transfer occurs.
- Reset mid-packet: all locks drop immediately; the upstream buffer is responsible for discarding the partial packet.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with output 2 locked -> sel2=0, gnt=0 immediately; ptr=0 after release.
- Single requester: valid=00001, req0=00100, out_rdy=11111, tail asserted on the 3rd granted cycle -> sel2=00001 from t+1, gnt=00001 for 3 cycles, then sel2=0 and ptr_2=1.
- Contention and round-robin: inputs 1, 3, 4 all request output 0 with 1-flit packets, ptr_0=0 -> grant order 1, 3, 4, 1 with a one-cycle bubble between locks.
- Backpressure: locked output 3 with out_rdy[3]=0 for 4 cycles -> sel3 held, gnt bit 0; tail on a non-granted cycle does not release.
- Timeout: TIMEOUT=8, owner never sends tail -> release after 8 locked cycles, next requester wins.
- Bad request: valid[2]=1, req2=00110 -> req_err=00100 pulse; input 2 receives no grant; other outputs unaffected.
